// File: rtl/reimu_life_pkg.sv
// Shared game package for the player life manager.
// Holds the life-state encoding and the lives counter width/limit.
package reimu_life_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAlive,
    StInvuln,
    StGameOver
  } life_state_e;

  localparam int unsigned          LIVES_W   = 3;
  localparam logic [LIVES_W-1:0]   LIVES_MAX = 3'd7;

endpackage

// File: rtl/reimu_life_ctrl.sv
// Player hit/life manager.
// Consumes the aggregated shot flag from the boss bullet stage and decides whether a hit costs
// a life, opens a timed invulnerability window with sprite blinking, or ends the game.
//
// Ports:
//   clk22      game tick clock
//   rst        asynchronous active-high reset
//   shot       level hit flag, sampled every clk22 edge
//   extend     one-cycle pulse granting an extra life (saturates at 7)
//   start      begins a new game from IDLE or GAME_OVER
//   lives      current life count
//   playing    high in ALIVE and INVULN
//   invuln     high in INVULN
//   visible    sprite enable; blinks on counter bit FLASH_SHIFT during INVULN
//   hit_pulse  one-cycle pulse per accepted hit
//   game_over  high in GAME_OVER
module reimu_life_ctrl
  import reimu_life_pkg::*;
#(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned INVULN_TICKS = 32,
  parameter int unsigned FLASH_SHIFT  = 2
) (
  input  logic               clk22,
  input  logic               rst,
  input  logic               shot,
  input  logic               extend,
  input  logic               start,
  output logic [LIVES_W-1:0] lives,
  output logic               playing,
  output logic               invuln,
  output logic               visible,
  output logic               hit_pulse,
  output logic               game_over
);

  localparam int unsigned CntW = (INVULN_TICKS > 2) ? $clog2(INVULN_TICKS) : 1;

  localparam logic [CntW-1:0]    CntLoad   = CntW'(INVULN_TICKS - 1);
  localparam logic [LIVES_W-1:0] LivesInit = LIVES_W'(LIVES_INIT);

  life_state_e        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               hit_q, hit_d;
  logic               playing_q, invuln_q, game_over_q;
  logic [LIVES_W-1:0] lives_inc;

  assign lives_inc = (lives_q == LIVES_MAX) ? LIVES_MAX : lives_q + LIVES_W'(1);

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    unique case (state_q)
      StIdle, StGameOver: begin
        if (start) begin
          state_d = StAlive;
          lives_d = LivesInit;
          cnt_d   = '0;
        end
      end
      StAlive: begin
        if (shot) begin
          hit_d = 1'b1;
          if (extend) begin
            // Hit and extend cancel out, so the player always survives this case.
            state_d = StInvuln;
            cnt_d   = CntLoad;
          end else if (lives_q <= LIVES_W'(1)) begin
            state_d = StGameOver;
            lives_d = '0;
          end else begin
            state_d = StInvuln;
            lives_d = lives_q - LIVES_W'(1);
            cnt_d   = CntLoad;
          end
        end else if (extend) begin
          lives_d = lives_inc;
        end
      end
      StInvuln: begin
        if (extend) lives_d = lives_inc;
        if (cnt_q == '0) begin
          state_d = StAlive;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk22 or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      lives_q     <= '0;
      cnt_q       <= '0;
      hit_q       <= 1'b0;
      playing_q   <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      playing_q   <= (state_d == StAlive) || (state_d == StInvuln);
      invuln_q    <= (state_d == StInvuln);
      game_over_q <= (state_d == StGameOver);
    end
  end

  always_comb begin
    visible = 1'b0;
    if (state_q == StAlive) begin
      visible = 1'b1;
    end else if (state_q == StInvuln) begin
      visible = cnt_q[FLASH_SHIFT];
    end
  end

  assign lives     = lives_q;
  assign playing   = playing_q;
  assign invuln    = invuln_q;
  assign hit_pulse = hit_q;
  assign game_over = game_over_q;

endmodule

// File: doc/reimu_life_ctrl.md
# reimu_life_ctrl

Player hit/life manager directly downstream of the boss bullet block. It consumes the aggregated `shot` hit flag and decides how a hit affects the player: lose a life, enter a timed invulnerability window with sprite blinking, or end the game. It drives the life counter, the visibility/blink signal for the renderer, and the `playing` enable that gates the rest of the game logic.

## Interface
Parameters:
- `LIVES_INIT`, default 3: lives loaded on start; legal range 1..7.
- `INVULN_TICKS`, default 32: length of the invulnerability window in clk22 cycles; legal range 2..1023.
- `FLASH_SHIFT`, default 2: blink half-period is 2^FLASH_SHIFT cycles; must satisfy 2^FLASH_SHIFT < INVULN_TICKS.

Ports:
- `clk22`  in  1: game tick clock; the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `shot`  in  1: level hit flag from the boss bullet stage; sampled every clk22 edge.
- `extend`  in  1: one-cycle pulse that grants one extra life.
- `start`  in  1: begins a new game; honoured only in IDLE and GAME_OVER.
- `lives`  out  3: current life count.
- `playing`  out  1: high in ALIVE and INVULN.
- `invuln`  out  1: high in INVULN.
- `visible`  out  1: sprite enable for the renderer.
- `hit_pulse`  out  1: one-cycle pulse per accepted hit.
- `game_over`  out  1: high in GAME_OVER.

## Operation
- States are IDLE, ALIVE, INVULN and GAME_OVER. Reset enters IDLE.
- **IDLE / GAME_OVER**
  - On `start`, go to ALIVE with `lives`=LIVES_INIT.
  - `shot` and `extend` are ignored.
- **ALIVE, `shot`=1 (accepted hit)**
  - `hit_pulse`=1 for the following cycle.
  - If the net lives value after the decrement and any simultaneous extend is 0, go to GAME_OVER with `lives`=0.
  - Otherwise `lives` is decremented, the counter is loaded with INVULN_TICKS-1, and the state goes to INVULN.
- **INVULN**
  - `shot` is ignored.
  - Each cycle, if the counter is 0, go to ALIVE; otherwise decrement the counter.
- **`extend`** in ALIVE or INVULN increments `lives`, saturating at 7.
- **`shot` and `extend` in the same ALIVE cycle:** both apply and the net lives value is unchanged. At `lives`=1 this results in INVULN with `lives`=1, not GAME_OVER.
- **`shot` held high for several cycles:** exactly one hit is taken. The first cycle enters INVULN and the rest are ignored.
- **Arithmetic:** `lives` is 3-bit unsigned and never wraps; decrement from 0 is unreachable. The counter width is $clog2(INVULN_TICKS), minimum 1.
- **`visible` decode:**
  - 1 in ALIVE.
  - In INVULN, equal to counter bit [FLASH_SHIFT].
  - 0 in IDLE and GAME_OVER.

## Timing
- Input sampled at edge N → state, `lives`, `invuln`, `playing`, `game_over` and `hit_pulse` all change at edge N (visible during cycle N+1).
- `hit_pulse` lasts exactly 1 cycle.
- The INVULN window lasts exactly INVULN_TICKS cycles; `shot` is next accepted on the first ALIVE cycle.
- `visible` is combinational from registered state and counter only. No input reaches an output combinationally.
- Reset values, applied asynchronously on `rst` assertion:
  - state IDLE
  - `lives`=0, `playing`=0, `invuln`=0, `visible`=0, `hit_pulse`=0, `game_over`=0
  - counter 0
- Reset mid-INVULN or mid-pulse clears everything immediately. After `rst` deasserts, the block waits for `start`.

## Structure
- Shared game package holds:
  - the life-state enum (IDLE, ALIVE, INVULN, GAME_OVER)
  - `LIVES_W`=3
  - `LIVES_MAX`=7
- A single module: one next-state block plus one register block. The counter is inline; no sub-module.

## Test plan
- Reset, then `start` → `lives`=3, `playing`=1, `visible`=1. Assert `rst` mid-INVULN → all outputs return to reset values before the next clk22 edge.
- In ALIVE with `lives`=3, pulse `shot` once → `lives`=2 and `hit_pulse` high for one cycle. `invuln` is high for exactly 32 cycles; a `shot` pulse at INVULN cycle 10 is ignored and `lives` stays 2.
- `shot` held high for 5 cycles in ALIVE → only one `hit_pulse`, `lives` drops by 1.
- Three hits spaced more than 32 cycles apart → after the third, `game_over`=1, `lives`=0, `playing`=0. Further `shot` has no effect; `start` then gives `lives`=3 in ALIVE.
- `extend` pulses at `lives`=7 → stays 7. Simultaneous `shot`+`extend` at `lives`=1 → INVULN with `lives`=1 and no GAME_OVER.
- With FLASH_SHIFT=2, INVULN_TICKS=32 → `visible` pattern after a hit is 1111 0000 1111 … for counter values 31 down to 0, then steady 1 in ALIVE.
